ysyx_22051013_lsu: RTL and testbench
====================================

YSYX_22051013_LSU -- requirements
Module: ysyx_22051013_lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 ls_inst in 32, ls_pc in 64, ls_rd_ena in 1, ls_rd_addr in 5  instruction context from the EX/LS register.
REQ-004 ls_exu_res in 64 (effective address or ALU result), ls_store_data in 64, ls_lsctl in 4  memory operation operands.
REQ-005 ls_lsctl encoding SHALL be: [3:2] 00 none, 01 load signed, 10 load unsigned, 11 store; [1:0] size 00 B, 01 H, 10 W, 11 D.
REQ-006 ls_flush in 1  kills write-back of the current LS instruction.
REQ-007 ls_ready out 1  high = LS busy; the EX/LS register SHALL hold.
REQ-008 mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 64 (8-byte aligned), mem_req_wen out 1, mem_req_wdata out 64, mem_req_wstrb out 8  request channel.
REQ-009 mem_rsp_valid in 1, mem_rdata in 64  response channel; one response per accepted request, never in the same cycle as acceptance.
REQ-010 wb_valid out 1, wb_inst out 32, wb_pc out 64, wb_rd_ena out 1, wb_rd_addr out 5, wb_rd_data out 64  registered LS/WB outputs.
REQ-011 ls_rd_addr_forward out 5, ls_rd_data_forward out 64, ls_misalign out 1  combinational forwarding and exception flag.

Function
REQ-012 FSM SHALL have exactly two states: IDLE, WAIT.
REQ-013 IDLE, lsctl[3:2]=00: ls_ready=0; the next edge SHALL load wb_* with ls_* context, wb_rd_data=ls_exu_res, wb_valid=1 (1-cycle latency).
REQ-014 IDLE with an aligned mem op and no flush: mem_req_valid=1, ls_ready=1; on mem_req_ready=1 -> WAIT; otherwise remain IDLE with the request held stable.
REQ-015 WAIT: mem_req_valid=0; ls_ready=!mem_rsp_valid; on mem_rsp_valid -> IDLE and wb_* captured on that edge.
REQ-016 Minimum mem-op latency SHALL be 2 cycles (accept, response).
REQ-017 Request address SHALL be {ls_exu_res[63:3],3'b000}; off=ls_exu_res[2:0].
REQ-018 Store: wdata=ls_store_data<<(8*off); wstrb=(B 0x01, H 0x03, W 0x0F, D 0xFF)<<off; wen=1.
REQ-019 Load: data=mem_rdata>>(8*off), truncated to size, sign- or zero-extended to 64 per lsctl[3:2].
REQ-020 Misaligned (H off[0]!=0, W off[1:0]!=0, D off!=0): ls_misalign=1, no request, ls_ready=0, wb_rd_ena=0, wb_valid=1.
REQ-021 Stores SHALL write wb_rd_ena=0 on completion.
REQ-022 ls_flush in IDLE: no request issued, ls_ready=0, next wb_valid=0, wb_rd_ena=0.
REQ-023 ls_flush in WAIT: set a kill flag; the transaction completes; on response wb_valid=0, wb_rd_ena=0; the flag clears on exit.
REQ-024 ls_rd_addr_forward=ls_rd_addr; ls_rd_data_forward=ls_exu_res.

Reset
REQ-025 rst low SHALL force IDLE, clear the kill flag, and zero all wb_* outputs; mem_req_valid=0 and ls_ready=0 while rst is low.
REQ-026 Reset in WAIT SHALL abandon the op; a later stale response in IDLE SHALL be ignored.

Structure
REQ-027 lsctl field encodings, size codes, and state encodings SHALL live in the shared define file.
REQ-028 Load extraction/extension and store lane/strobe generation SHALL form one combinational sub-module, ysyx_22051013_lsu_align.

Verification
REQ-029 lsctl=0, exu_res=0x1234 -> next cycle wb_rd_data=0x1234, wb_valid=1, ls_ready never high.
REQ-030 lb signed, addr 0x8000_0003, rdata 0x0000_0000_8000_0000 -> wb_rd_data=0xFFFF_FFFF_FFFF_FF80 after 2 cycles.
REQ-031 sh, addr 0x8000_0006, data 0xABCD -> wdata 0xABCD_0000_0000_0000, wstrb 0xC0, wen=1, wb_rd_ena=0.
REQ-032 lw, addr 0x...2 -> ls_misalign=1, mem_req_valid stays 0.
REQ-033 ld with mem_req_ready low 3 cycles and rsp after 2 more -> ls_ready high exactly 6 cycles, request stable.
REQ-034 ls_flush in WAIT -> response consumed, wb_valid=0; rst low in WAIT -> IDLE, stale response ignored.

Source files
------------

// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared encodings for the load/store unit: lsctl fields, access sizes and FSM states.
package ysyx_22051013_lsu_pkg;

  localparam logic [1:0] LS_OP_NONE   = 2'b00;
  localparam logic [1:0] LS_OP_LOAD_S = 2'b01;
  localparam logic [1:0] LS_OP_LOAD_U = 2'b10;
  localparam logic [1:0] LS_OP_STORE  = 2'b11;

  localparam logic [1:0] LS_SIZE_B = 2'b00;
  localparam logic [1:0] LS_SIZE_H = 2'b01;
  localparam logic [1:0] LS_SIZE_W = 2'b10;
  localparam logic [1:0] LS_SIZE_D = 2'b11;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  // An access is misaligned when it would straddle its natural boundary.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic res;
    res = 1'b0;
    case (size)
      LS_SIZE_H: res = off[0];
      LS_SIZE_W: res = (off[1:0] != 2'b00);
      LS_SIZE_D: res = (off != 3'b000);
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with sign/zero extension.
module ysyx_22051013_lsu_align
  import ysyx_22051013_lsu_pkg::*;
(
  input  logic [3:0]  lsctl,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [7:0]  strb_base;
  logic [63:0] shifted;
  logic        sign_ext;

  assign shamt    = {off, 3'b000};
  assign wdata    = store_data << shamt;
  assign wstrb    = strb_base << off;
  assign shifted  = rdata >> shamt;
  assign sign_ext = (lsctl[3:2] == LS_OP_LOAD_S);

  always_comb begin
    strb_base = 8'h01;
    case (lsctl[1:0])
      LS_SIZE_B: strb_base = 8'h01;
      LS_SIZE_H: strb_base = 8'h03;
      LS_SIZE_W: strb_base = 8'h0F;
      LS_SIZE_D: strb_base = 8'hFF;
      default:   strb_base = 8'h01;
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (lsctl[1:0])
      LS_SIZE_B: load_data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      LS_SIZE_H: load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      LS_SIZE_W: load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      LS_SIZE_D: load_data = shifted;
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store stage: issues one memory request per mem op, waits for its response, and registers LS/WB results.
module ysyx_22051013_lsu
  import ysyx_22051013_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ls_inst,
  input  logic [63:0] ls_pc,
  input  logic        ls_rd_ena,
  input  logic [4:0]  ls_rd_addr,
  input  logic [63:0] ls_exu_res,
  input  logic [63:0] ls_store_data,
  input  logic [3:0]  ls_lsctl,
  input  logic        ls_flush,
  output logic        ls_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_inst,
  output logic [63:0] wb_pc,
  output logic        wb_rd_ena,
  output logic [4:0]  wb_rd_addr,
  output logic [63:0] wb_rd_data,
  output logic [4:0]  ls_rd_addr_forward,
  output logic [63:0] ls_rd_data_forward,
  output logic        ls_misalign
);

  lsu_state_e  state_q, state_d;
  logic        kill_q, kill_d;
  logic        wb_valid_q, wb_valid_d, wb_rd_ena_q, wb_rd_ena_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [63:0] wb_pc_q, wb_pc_d, wb_rd_data_q, wb_rd_data_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;

  logic [1:0]  op;
  logic        is_mem, is_load, is_store, misalign, issue, killed;
  logic        req_valid_c, busy_c;
  logic [63:0] align_wdata, load_data;
  logic [7:0]  align_wstrb;

  assign op       = ls_lsctl[3:2];
  assign is_mem   = (op != LS_OP_NONE);
  assign is_store = (op == LS_OP_STORE);
  assign is_load  = is_mem && !is_store;
  assign misalign = is_mem && lsu_misaligned(ls_lsctl[1:0], ls_exu_res[2:0]);
  assign issue    = is_mem && !misalign && !ls_flush;
  assign killed   = kill_q | ls_flush;

  ysyx_22051013_lsu_align u_align (
    .lsctl      (ls_lsctl),
    .off        (ls_exu_res[2:0]),
    .store_data (ls_store_data),
    .rdata      (mem_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LSU_IDLE;
      kill_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_inst_q    <= '0;
      wb_pc_q      <= '0;
      wb_rd_ena_q  <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      wb_valid_q   <= wb_valid_d;
      wb_inst_q    <= wb_inst_d;
      wb_pc_q      <= wb_pc_d;
      wb_rd_ena_q  <= wb_rd_ena_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (issue && mem_req_ready) state_d = LSU_WAIT;
      LSU_WAIT: if (mem_rsp_valid)          state_d = LSU_IDLE;
      default:                              state_d = LSU_IDLE;
    endcase
  end

  // wb_valid pulses only on the cycle an instruction retires from LS; other wb fields hold.
  always_comb begin
    req_valid_c  = 1'b0;
    busy_c       = 1'b0;
    kill_d       = kill_q;
    wb_valid_d   = 1'b0;
    wb_inst_d    = wb_inst_q;
    wb_pc_d      = wb_pc_q;
    wb_rd_ena_d  = wb_rd_ena_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    case (state_q)
      LSU_IDLE: begin
        kill_d = 1'b0;
        if (ls_flush) begin
          wb_rd_ena_d = 1'b0;
        end else if (!is_mem || misalign) begin
          wb_valid_d   = 1'b1;
          wb_inst_d    = ls_inst;
          wb_pc_d      = ls_pc;
          wb_rd_ena_d  = ls_rd_ena && !misalign;
          wb_rd_addr_d = ls_rd_addr;
          wb_rd_data_d = ls_exu_res;
        end else begin
          req_valid_c = 1'b1;
          busy_c      = 1'b1;
        end
      end
      LSU_WAIT: begin
        busy_c = !mem_rsp_valid;
        kill_d = killed;
        if (mem_rsp_valid) begin
          kill_d       = 1'b0;
          wb_valid_d   = !killed;
          wb_inst_d    = ls_inst;
          wb_pc_d      = ls_pc;
          wb_rd_ena_d  = !killed && is_load && ls_rd_ena;
          wb_rd_addr_d = ls_rd_addr;
          wb_rd_data_d = is_load ? load_data : ls_exu_res;
        end
      end
      default: begin
        kill_d = 1'b0;
      end
    endcase
  end

  assign mem_req_valid      = rst && req_valid_c;
  assign ls_ready           = rst && busy_c;
  assign mem_req_addr       = {ls_exu_res[63:3], 3'b000};
  assign mem_req_wen        = is_store;
  assign mem_req_wdata      = align_wdata;
  assign mem_req_wstrb      = is_store ? align_wstrb : 8'h00;
  assign ls_misalign        = misalign;
  assign ls_rd_addr_forward = ls_rd_addr;
  assign ls_rd_data_forward = ls_exu_res;

  assign wb_valid   = wb_valid_q;
  assign wb_inst    = wb_inst_q;
  assign wb_pc      = wb_pc_q;
  assign wb_rd_ena  = wb_rd_ena_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_rd_data = wb_rd_data_q;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Self-checking bench: acts as EX/LS register and memory, compares against a transaction-level LSU model.
module tb_ysyx_22051013_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ls_inst = '0;
  logic [63:0] ls_pc = '0;
  logic        ls_rd_ena = 1'b0;
  logic [4:0]  ls_rd_addr = '0;
  logic [63:0] ls_exu_res = '0;
  logic [63:0] ls_store_data = '0;
  logic [3:0]  ls_lsctl = '0;
  logic        ls_flush = 1'b0;
  logic        ls_ready;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [63:0] wb_pc;
  logic        wb_rd_ena;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic [4:0]  ls_rd_addr_forward;
  logic [63:0] ls_rd_data_forward;
  logic        ls_misalign;

  int compareCount = 0;
  int mismatchCount = 0;

  ysyx_22051013_lsu dut (
    .clk(clk), .rst(rst),
    .ls_inst(ls_inst), .ls_pc(ls_pc), .ls_rd_ena(ls_rd_ena), .ls_rd_addr(ls_rd_addr),
    .ls_exu_res(ls_exu_res), .ls_store_data(ls_store_data), .ls_lsctl(ls_lsctl),
    .ls_flush(ls_flush), .ls_ready(ls_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc), .wb_rd_ena(wb_rd_ena),
    .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .ls_rd_addr_forward(ls_rd_addr_forward), .ls_rd_data_forward(ls_rd_data_forward),
    .ls_misalign(ls_misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
    end
  endtask

  // Model: gather the accessed bytes from the doubleword, then extend to 64 bits.
  function automatic logic [63:0] refLoad(input logic [63:0] rdata, input logic [2:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [63:0] v;
    int n;
    int base;
    v = '0;
    n = 1 << size;
    base = int'(off);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(base+i) +: 8];
    if (sgn && v[8*n-1]) for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] refStrb(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < (1 << size); i++) s[int'(off) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic refMisalign(input logic [1:0] size, input logic [2:0] off);
    int bytes;
    bytes = 1 << size;
    return (int'(off) % bytes) != 0;
  endfunction

  // One LS instruction: held inputs, memory with given accept/response delays, optional flush.
  task automatic applyStimulus(input logic [3:0] lsctl, input logic [63:0] exu_res,
                               input logic [63:0] store_data, input logic [63:0] rdata,
                               input logic rd_ena, input logic flush_idle,
                               input int acc_delay, input int rsp_delay, input int kill_at);
    logic [1:0]  op;
    logic [1:0]  size;
    logic [2:0]  off;
    logic        mis, is_load, is_store, killed;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [4:0]  rd_addr;
    int          busy;
    op = lsctl[3:2];
    size = lsctl[1:0];
    off = exu_res[2:0];
    is_store = (op == 2'b11);
    is_load = (op == 2'b01) || (op == 2'b10);
    mis = (op != 2'b00) && refMisalign(size, off);
    inst = $urandom;
    pc = {$urandom, $urandom};
    rd_addr = 5'($urandom);
    ls_inst = inst;
    ls_pc = pc;
    ls_rd_addr = rd_addr;
    ls_rd_ena = rd_ena;
    ls_lsctl = lsctl;
    ls_exu_res = exu_res;
    ls_store_data = store_data;
    ls_flush = flush_idle;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (op == 2'b00 || mis || flush_idle) begin
      @(negedge clk);
      checkOutput("ready_single", 64'(ls_ready), 64'd0);
      checkOutput("req_single", 64'(mem_req_valid), 64'd0);
      checkOutput("misalign", 64'(ls_misalign), 64'(mis));
      checkOutput("fwd_addr", 64'(ls_rd_addr_forward), 64'(rd_addr));
      checkOutput("fwd_data", ls_rd_data_forward, exu_res);
      @(posedge clk); #1;
      ls_flush = 1'b0;
      checkOutput("wb_valid_single", 64'(wb_valid), 64'(!flush_idle));
      checkOutput("wb_rd_ena_single", 64'(wb_rd_ena), 64'(!flush_idle && !mis && op == 2'b00 && rd_ena));
      if (!flush_idle) begin
        checkOutput("wb_pc_single", wb_pc, pc);
        checkOutput("wb_inst_single", 64'(wb_inst), 64'(inst));
        checkOutput("wb_rd_addr_single", 64'(wb_rd_addr), 64'(rd_addr));
        if (op == 2'b00) checkOutput("wb_rd_data_alu", wb_rd_data, exu_res);
      end
    end else begin
      busy = 0;
      killed = 1'b0;
      for (int c = 0; c <= acc_delay; c++) begin
        mem_req_ready = (c == acc_delay);
        @(negedge clk);
        checkOutput("req_valid", 64'(mem_req_valid), 64'd1);
        checkOutput("misalign_ok", 64'(ls_misalign), 64'd0);
        checkOutput("req_addr", mem_req_addr, {exu_res[63:3], 3'b000});
        checkOutput("req_wen", 64'(mem_req_wen), 64'(is_store));
        if (is_store) begin
          checkOutput("req_wdata", mem_req_wdata, store_data << (8 * int'(off)));
          checkOutput("req_wstrb", 64'(mem_req_wstrb), 64'(refStrb(off, size)));
        end
        busy += int'(ls_ready);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      for (int w = 0; w <= rsp_delay; w++) begin
        mem_rsp_valid = (w == rsp_delay);
        mem_rdata = (w == rsp_delay) ? rdata : {$urandom, $urandom};
        ls_flush = (w == kill_at);
        if (w == kill_at) killed = 1'b1;
        @(negedge clk);
        checkOutput("req_in_wait", 64'(mem_req_valid), 64'd0);
        busy += int'(ls_ready);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
      ls_flush = 1'b0;
      checkOutput("busy_cycles", 64'(busy), 64'(acc_delay + 1 + rsp_delay));
      checkOutput("wb_valid_mem", 64'(wb_valid), 64'(!killed));
      checkOutput("wb_rd_ena_mem", 64'(wb_rd_ena), 64'(!killed && is_load && rd_ena));
      if (!killed) begin
        checkOutput("wb_pc_mem", wb_pc, pc);
        checkOutput("wb_rd_addr_mem", 64'(wb_rd_addr), 64'(rd_addr));
        if (is_load) checkOutput("wb_load_data", wb_rd_data, refLoad(rdata, off, size, op == 2'b01));
      end
    end
  endtask

  initial begin
    logic [3:0] r_ctl;
    logic [63:0] r_addr;
    int r_kill;
    // Reset holds everything quiet even with a mem op presented.
    ls_lsctl = 4'b0110;
    @(negedge clk);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_ready", 64'(ls_ready), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_data", wb_rd_data, 64'd0);
    checkOutput("rst_wb_pc", wb_pc, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    applyStimulus(4'b0000, 64'h1234, 64'd0, 64'd0, 1'b1, 1'b0, 0, 0, -1);
    applyStimulus(4'b0100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 0, 0, -1);
    applyStimulus(4'b1101, 64'h8000_0006, 64'hABCD, 64'd0, 1'b1, 1'b0, 0, 0, -1);
    applyStimulus(4'b0110, 64'h8000_0002, 64'd0, 64'd0, 1'b1, 1'b0, 0, 0, -1);
    applyStimulus(4'b0111, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 3, 2, -1);
    applyStimulus(4'b1000, 64'h8000_0007, 64'd0, 64'hFF00_0000_0000_0000, 1'b1, 1'b0, 1, 1, 1);
    applyStimulus(4'b0100, 64'h8000_0007, 64'd0, 64'hFF00_0000_0000_0000, 1'b1, 1'b1, 0, 0, -1);

    // Reset while waiting for a response, then a stale response arrives in IDLE.
    ls_lsctl = 4'b0111;
    ls_exu_res = 64'h8000_0040;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_wait_req", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_wait_ready", 64'(ls_ready), 64'd0);
    checkOutput("rst_wait_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wait_wb_data", wb_rd_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    checkOutput("stale_req_reissued", 64'(mem_req_valid), 64'd1);
    checkOutput("stale_ready", 64'(ls_ready), 64'd1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    checkOutput("stale_wb_valid", 64'(wb_valid), 64'd0);

    for (int t = 0; t < 300; t++) begin
      r_ctl = 4'($urandom);
      r_addr = {$urandom, $urandom};
      r_kill = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      applyStimulus(r_ctl, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_kill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
